uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path between several response sources: command dispatcher replies, memory read data and error/status messages.
- Each source delivers byte packets that are delimited by a last flag. The arbiter grants one source at a time using round-robin order and holds the grant until that packet's last byte is accepted. This keeps messages atomic on the serial line.
- Drives the command-FIFO-style read interface of uart_tx_tlb (data, valid, rd_en) through a one-entry output register.

Parameters:
- NUM_REQ, 3, number of requesting sources (2..8).
- DATA_W, 8, byte width per transfer.
- TIMEOUT_CYCLES, 4096, stall limit for the optional watchdog.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-low reset; the block is in reset while rst==0 at a clk rising edge.
- req_valid  input  NUM_REQ  per-source byte valid.
- req_data  input  NUM_REQ*DATA_W  per-source byte; source i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  marks the final byte of a packet.
- req_ready  output  NUM_REQ  per-source accept.
- cmd_fifo_rd_data  output  DATA_W  byte presented to uart_tx.
- cmd_fifo_valid  output  1  cmd_fifo_rd_data is valid.
- cmd_fifo_rd_en  input  1  uart_tx pops the presented byte.
- grant_id  output  $clog2(NUM_REQ)  currently granted source.
- busy  output  1  a packet is locked.

Behaviour:
- Reset values:
  - cmd_fifo_valid=0, cmd_fifo_rd_data=0.
  - req_ready=0, grant_id=0, busy=0.
  - Round-robin pointer=0; FSM in IDLE.
- FSM states:
  - IDLE: when any req_valid is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ. Latch it into grant_id, set busy, go to LOCK next cycle.
  - LOCK: req_ready[grant_id] = (!cmd_fifo_valid || cmd_fifo_rd_en); all other ready bits are 0.
    - A source transfer occurs when req_valid && req_ready.
    - The transfer loads the output register and sets cmd_fifo_valid.
    - A transfer with req_last returns the FSM to IDLE, sets pointer=grant_id+1 mod NUM_REQ, and clears busy the next cycle.
- Output register:
  - cmd_fifo_valid clears when cmd_fifo_rd_en is sampled high and no new byte loads in the same cycle.
  - A simultaneous pop and load keeps valid=1 with the new data, giving one byte per cycle of throughput.
  - cmd_fifo_rd_en while cmd_fifo_valid=0 is ignored.
- Latency:
  - req_valid rising in IDLE at cycle N: grant at N+1, first byte accepted at N+1, cmd_fifo_valid high at N+2.
  - The next packet from another source cannot be granted before the cycle after the last byte is accepted.
- Grant rules:
  - The grant never changes mid-packet.
  - Requests arriving from other sources during LOCK wait.
  - A requester dropping req_valid mid-packet stalls the lock; the grant is kept.
- The last byte of a packet may still sit in the output register while IDLE arbitrates. The new packet's first byte waits on the req_ready rule.
- Reset mid-packet:
  - Output register and FSM clear immediately.
  - The partial packet is abandoned and no byte is replayed.
- grant_id outside 0..NUM_REQ-1 is unreachable.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCK cycle without a source transfer and resets on each transfer.
  - On reaching TIMEOUT_CYCLES, the FSM forces IDLE and advances the pointer past grant_id.
  - It also pulses an extra output port, timeout_pulse (1 bit, reset 0), for one cycle.
- Undefined: no counter and no timeout_pulse port; a stalled source holds the lock indefinitely.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - typedef arb_state_e {IDLE, LOCK};
  - localparam defaults NUM_REQ_DEF=3, DATA_W_DEF=8, TIMEOUT_DEF=4096.
- One natural sub-module, rr_pick: a combinational round-robin priority select taking the request vector and pointer, returning the winner index and a found flag.

Test Plan:
- Single source 0 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3) with rd_en tied 1:
  - grant_id=0 at N+1.
  - cmd_fifo_valid at N+2 for 3 consecutive cycles carrying 0xA1,0xA2,0xA3.
  - busy falls after 0xA3 is accepted.
- Sources 0 and 2 both request 2-byte packets in the same cycle from reset:
  - Source 0 is served first, then source 2.
  - No interleaving: output sequence is 0x10,0x11,0x30,0x31.
- All three sources request continuously with 1-byte packets:
  - Grant order is 0,1,2,0,1,2 (round-robin fairness).
- Output backpressure: rd_en=0 for 5 cycles while source 1 streams:
  - Exactly one byte is held in the output register.
  - req_ready[1]=0 until rd_en=1.
  - No byte is lost or duplicated.
- Reset (rst=0) asserted after byte 2 of a 4-byte packet:
  - All outputs are 0 next cycle.
  - After release, a new request from source 1 is granted from pointer 0.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: source 0 drops valid mid-packet while source 1 waits.
  - timeout_pulse fires after 16 stall cycles.
  - Source 1 is granted.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared types and default parameters for the UART transmit arbiter slice.
//   arb_state_e  : arbiter FSM states (IDLE arbitrates, LOCK holds a packet)
//   *_DEF        : default values for NUM_REQ, DATA_W and the watchdog limit
package uart_tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF = 3;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority select.
//   req   [NUM_REQ-1:0] : request vector
//   ptr   [IDX_W-1:0]   : index with highest priority this round
//   idx   [IDX_W-1:0]   : first set request at or after ptr, wrapping
//   found               : at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int unsigned cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit path between several packet sources. A source is
// granted round-robin and keeps the grant until its last byte is accepted,
// so packets never interleave on the line. Accepted bytes go through a
// one-entry output register read by uart_tx like a command FIFO.
//
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   req_valid/last    : per-source byte valid / end-of-packet
//   req_data          : source i at [i*DATA_W +: DATA_W]
//   req_ready         : per-source accept (only the granted source)
//   cmd_fifo_rd_data  : byte presented to uart_tx
//   cmd_fifo_valid    : presented byte is valid
//   cmd_fifo_rd_en    : uart_tx pops the presented byte
//   grant_id, busy    : granted source, packet locked
//   timeout_pulse     : one-cycle stall-watchdog pulse (UART_TX_ARB_TIMEOUT_EN only)
//
// Build option: define UART_TX_ARB_TIMEOUT_EN to add the stall watchdog.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          cmd_fifo_rd_data,
    output logic                       cmd_fifo_valid,
    input  logic                       cmd_fifo_rd_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                       timeout_pulse
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e        state, state_nx;
    logic [IDX_W-1:0]  ptr, ptr_nx, grant_nx, pick_idx;
    logic              busy_nx, pick_found;
    logic              can_load, xfer, xfer_last, force_idle;
    logic [DATA_W-1:0] xfer_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The output register can take a byte when empty or being popped now.
    always_comb begin
        can_load  = !cmd_fifo_valid || cmd_fifo_rd_en;
        req_ready = '0;
        if (state == LOCK && can_load) begin
            req_ready[grant_id] = 1'b1;
        end
        xfer      = |(req_valid & req_ready);
        xfer_data = req_data[grant_id*DATA_W +: DATA_W];
        xfer_last = req_last[grant_id];
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] stall_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled LOCK cycle.
    always_comb begin
        force_idle = (state == LOCK) && !xfer &&
                     (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt     <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= force_idle;
            if (state != LOCK || xfer || force_idle) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign force_idle = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        grant_nx = grant_id;
        busy_nx  = busy;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nx = pick_idx;
                    busy_nx  = 1'b1;
                    state_nx = LOCK;
                end
            end
            LOCK: begin
                if ((xfer && xfer_last) || force_idle) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    ptr_nx   = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            ptr              <= '0;
            grant_id         <= '0;
            busy             <= 1'b0;
            cmd_fifo_valid   <= 1'b0;
            cmd_fifo_rd_data <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            grant_id <= grant_nx;
            busy     <= busy_nx;
            if (xfer) begin
                cmd_fifo_rd_data <= xfer_data;
                cmd_fifo_valid   <= 1'b1;
            end else if (cmd_fifo_rd_en) begin
                cmd_fifo_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_REQ=3, DATA_W=8): a cycle
// vector table, directed multi-cycle sequences and a randomized packet
// stream scored against per-source packet lists.
module tb_uart_tx_arbiter;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   cmd_fifo_rd_data;
    logic           cmd_fifo_valid;
    logic           cmd_fifo_rd_en;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic           timeout_pulse;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .cmd_fifo_rd_data (cmd_fifo_rd_data),
        .cmd_fifo_valid   (cmd_fifo_valid),
        .cmd_fifo_rd_en   (cmd_fifo_rd_en),
        .grant_id         (grant_id),
        .busy             (busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .timeout_pulse    (timeout_pulse)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid      = '0;
        req_data       = '0;
        req_last       = '0;
        cmd_fifo_rd_en = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  vld;
        logic [23:0] data;
        logic [2:0]  last;
        logic        rd_en;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [2:0]  exp_ready;
        logic [1:0]  exp_grant;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [23:0] d,
                                input logic [2:0] l, input logic re, input logic ev,
                                input logic [7:0] ed, input logic [2:0] er,
                                input logic [1:0] eg, input logic eb);
        vec_t x;
        x.rst = r; x.vld = v; x.data = d; x.last = l; x.rd_en = re;
        x.exp_valid = ev; x.exp_data = ed; x.exp_ready = er; x.exp_grant = eg; x.exp_busy = eb;
        return x;
    endfunction

    // random-test packet lists
    logic [7:0]  pkt_byte [N][64];
    logic        pkt_last [N][64];
    int unsigned n_bytes [N];
    int unsigned sent    [N];
    int unsigned popped  [N];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned got, idx, s, total_b, total_p, pulses;
        logic [N-1:0] acc;
        logic pop, in_pkt, lst, done;
        logic [7:0] pb;
        int unsigned cur_src;
        logic [7:0] bp_q[$];

        do_reset();

        // ---------------- reset values ----------------
        @(negedge clk);
        check("reset valid", 32'(cmd_fifo_valid), 32'd0);
        check("reset data",  32'(cmd_fifo_rd_data), 32'd0);
        check("reset ready", 32'(req_ready), 32'd0);
        check("reset grant", 32'(grant_id), 32'd0);
        check("reset busy",  32'(busy), 32'd0);
        tick();

        // ---------------- vector table ----------------
        // single source 0: A1,A2,A3; then reset; then sources 0 and 2 together
        tbl.push_back(mk(1'b1, 3'b001, 24'h0000A1, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 3'b001, 24'h0000A1, 3'b000, 1'b1, 1'b0, 8'h00, 3'b001, 2'd0, 1'b1));
        tbl.push_back(mk(1'b1, 3'b001, 24'h0000A2, 3'b000, 1'b1, 1'b1, 8'hA1, 3'b001, 2'd0, 1'b1));
        tbl.push_back(mk(1'b1, 3'b001, 24'h0000A3, 3'b001, 1'b1, 1'b1, 8'hA2, 3'b001, 2'd0, 1'b1));
        tbl.push_back(mk(1'b1, 3'b000, 24'h000000, 3'b000, 1'b1, 1'b1, 8'hA3, 3'b000, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 3'b101, 24'h300010, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 3'b101, 24'h300010, 3'b000, 1'b1, 1'b0, 8'h00, 3'b001, 2'd0, 1'b1));
        tbl.push_back(mk(1'b1, 3'b101, 24'h300011, 3'b001, 1'b1, 1'b1, 8'h10, 3'b001, 2'd0, 1'b1));
        tbl.push_back(mk(1'b1, 3'b100, 24'h300000, 3'b000, 1'b1, 1'b1, 8'h11, 3'b000, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 3'b100, 24'h300000, 3'b000, 1'b1, 1'b0, 8'h00, 3'b100, 2'd2, 1'b1));
        tbl.push_back(mk(1'b1, 3'b100, 24'h310000, 3'b100, 1'b1, 1'b1, 8'h30, 3'b100, 2'd2, 1'b1));
        tbl.push_back(mk(1'b1, 3'b000, 24'h000000, 3'b000, 1'b1, 1'b1, 8'h31, 3'b000, 2'd2, 1'b0));
        tbl.push_back(mk(1'b1, 3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 2'd2, 1'b0));

        foreach (tbl[i]) begin
            rst            = tbl[i].rst;
            req_valid      = tbl[i].vld;
            req_data       = tbl[i].data;
            req_last       = tbl[i].last;
            cmd_fifo_rd_en = tbl[i].rd_en;
            @(negedge clk);
            check($sformatf("row%0d valid", i), 32'(cmd_fifo_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                check($sformatf("row%0d data", i), 32'(cmd_fifo_rd_data), 32'(tbl[i].exp_data));
            check($sformatf("row%0d ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
            check($sformatf("row%0d grant", i), 32'(grant_id), 32'(tbl[i].exp_grant));
            check($sformatf("row%0d busy", i),  32'(busy), 32'(tbl[i].exp_busy));
            tick();
        end
        rst = 1'b1;

        // ---------------- round-robin fairness ----------------
        do_reset();
        req_valid = 3'b111;
        req_last  = 3'b111;
        req_data  = 24'hC2C1C0;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (acc != '0) begin
                s = 0;
                for (int unsigned k = 0; k < N; k++) if (acc[k]) s = k;
                check($sformatf("rr order %0d", got), s, got % 3);
                got++;
            end
            tick();
        end
        check("rr count", got, 32'd6);

        // ---------------- output backpressure ----------------
        do_reset();
        cmd_fifo_rd_en = 1'b0;
        idx = 0;
        bp_q.delete();
        for (int c = 0; c < 40; c++) begin
            req_valid = (idx < 4) ? 3'b010 : 3'b000;
            req_data  = '0;
            req_data[15:8] = 8'h51 + 8'(idx);
            req_last  = (idx == 3) ? 3'b010 : 3'b000;
            cmd_fifo_rd_en = (c >= 7);
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                check($sformatf("bp held ready c%0d", c), 32'(req_ready), 32'd0);
                check($sformatf("bp held data c%0d", c), {31'd0, cmd_fifo_valid} << 8 | 32'(cmd_fifo_rd_data), 32'h151);
            end
            if (c == 7) check("bp release ready", 32'(req_ready), 32'b010);
            if (cmd_fifo_valid && cmd_fifo_rd_en) bp_q.push_back(cmd_fifo_rd_data);
            if (req_valid[1] && req_ready[1]) idx++;
            tick();
            if (idx == 4 && bp_q.size() == 4) break;
        end
        check("bp byte count", bp_q.size(), 32'd4);
        for (int unsigned k = 0; k < 4; k++) begin
            if (k < bp_q.size())
                check($sformatf("bp byte %0d", k), 32'(bp_q[k]), 32'h51 + k);
        end

        // ---------------- reset mid-packet ----------------
        do_reset();
        // one-byte packet from source 1 moves the pointer to 2
        req_valid = 3'b010; req_data = 24'h007700; req_last = 3'b010;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            done = req_valid[1] && req_ready[1];
            tick();
        end
        check("rstmid src1 accepted", 32'(done), 32'd1);
        idx = 0;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            req_valid = 3'b001;
            req_data  = 24'h0 | (24'h61 + 24'(idx));
            req_last  = (idx == 3) ? 3'b001 : 3'b000;
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) idx++;
            tick();
        end
        check("rstmid bytes before reset", idx, 32'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("rstmid valid", 32'(cmd_fifo_valid), 32'd0);
        check("rstmid data",  32'(cmd_fifo_rd_data), 32'd0);
        check("rstmid ready", 32'(req_ready), 32'd0);
        check("rstmid grant", 32'(grant_id), 32'd0);
        check("rstmid busy",  32'(busy), 32'd0);
        tick();
        req_valid = 3'b110; req_data = 24'h998800; req_last = 3'b110;
        @(negedge clk);
        check("rstmid no replay", 32'(cmd_fifo_valid), 32'd0);
        tick();
        @(negedge clk);
        check("rstmid grant after", 32'(grant_id), 32'd1);
        check("rstmid busy after",  32'(busy), 32'd1);
        check("rstmid ready after", 32'(req_ready), 32'b010);
        tick();

`ifdef UART_TX_ARB_TIMEOUT_EN
        // ---------------- stall watchdog ----------------
        do_reset();
        req_valid = 3'b011; req_data = 24'h00E8E0; req_last = 3'b010;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("to first ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b010;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (timeout_pulse) pulses++;
            tick();
        end
        check("to no early pulse", pulses, 32'd0);
        @(negedge clk);
        check("to pulse", 32'(timeout_pulse), 32'd1);
        check("to busy drop", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        check("to pulse width", 32'(timeout_pulse), 32'd0);
        check("to grant src1", 32'(grant_id), 32'd1);
        check("to busy src1", 32'(busy), 32'd1);
        tick();
`endif

        // ---------------- randomized packet stream ----------------
        do_reset();
        total_b = 0;
        for (int unsigned ss = 0; ss < N; ss++) begin
            n_bytes[ss] = 0; sent[ss] = 0; popped[ss] = 0;
            for (int p = 0; p < 10; p++) begin
                int unsigned len;
                len = $urandom_range(1, 4);
                for (int unsigned b = 0; b < len; b++) begin
                    pkt_byte[ss][n_bytes[ss]] = {ss[1:0], n_bytes[ss][5:0]};
                    pkt_last[ss][n_bytes[ss]] = (b == len - 1);
                    n_bytes[ss]++;
                end
            end
            total_b += n_bytes[ss];
        end
        in_pkt = 1'b0; cur_src = 0; total_p = 0;
        for (int cyc = 0; cyc < 5000 && total_p < total_b; cyc++) begin
            for (int unsigned ss = 0; ss < N; ss++) begin
                req_valid[ss] = (sent[ss] < n_bytes[ss]) && ($urandom_range(0, 9) < 7);
                req_data[ss*W +: W] = pkt_byte[ss][sent[ss]];
                req_last[ss] = pkt_last[ss][sent[ss]];
            end
            cmd_fifo_rd_en = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("rand ready onehot", 32'($countones(req_ready) <= 1), 32'd1);
            acc = req_valid & req_ready;
            pop = cmd_fifo_valid && cmd_fifo_rd_en;
            pb  = cmd_fifo_rd_data;
            tick();
            for (int unsigned ss = 0; ss < N; ss++) if (acc[ss]) sent[ss]++;
            if (pop) begin
                s = 32'(pb[7:6]);
                total_p++;
                if (s >= N || popped[s] >= n_bytes[s]) begin
                    check("rand unexpected byte", 32'(pb), 32'hFFFF_FFFF);
                end else begin
                    if (in_pkt) check("rand atomic src", s, cur_src);
                    check("rand byte", 32'(pb), 32'(pkt_byte[s][popped[s]]));
                    lst = pkt_last[s][popped[s]];
                    popped[s]++;
                    in_pkt  = !lst;
                    cur_src = s;
                end
            end
        end
        check("rand drained", total_p, total_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
